// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared state type and constants for the convolution sequencer
package conv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN
    } state_t;

    localparam int W_BASE_DEF = 4080;
    localparam int LANE_W     = 16;

endpackage

// File: rtl/bn_packer.sv
// rtl/bn_packer.sv - packs conv results into BN lanes, one-deep pending slot and BN handshake
module bn_packer
    import conv_seq_pkg::*;
#(
    parameter int BN_GROUP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [LANE_W-1:0]          lane_in,
    input  logic                       lane_valid,
    input  logic                       flush,
    input  logic                       bn_done,
    output logic [BN_GROUP*LANE_W-1:0] bn_input,
    output logic                       bn_start,
    output logic                       ovf,
    output logic                       idle
);

    localparam int GW = BN_GROUP * LANE_W;
    localparam int CW = $clog2(BN_GROUP + 1);
    localparam logic [CW-1:0] LAST = CW'(BN_GROUP - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [GW-1:0] acc;
    logic [GW-1:0] grp;
    logic [GW-1:0] pend;
    logic [CW-1:0] cnt;
    logic          pend_v;
    logic          eng_busy;
    logic          complete;
    logic          eng_free;

    // acc keeps unfilled lanes at zero, so a flushed partial group is zero-padded
    always_comb begin
        grp = acc;
        if (lane_valid) grp[LANE_W*int'(cnt) +: LANE_W] = lane_in;
        complete = (lane_valid && cnt == LAST) || (flush && (lane_valid || cnt != '0));
        eng_free = !eng_busy || bn_done;
    end

    assign idle = !eng_busy && !pend_v && cnt == '0;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc      <= '0;
            pend     <= '0;
            cnt      <= '0;
            pend_v   <= 1'b0;
            eng_busy <= 1'b0;
            bn_input <= '0;
            bn_start <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            bn_start <= 1'b0;
            if (lane_valid) begin
                acc <= grp;
                cnt <= cnt + ONE;
            end
            if (complete) begin
                acc <= '0;
                cnt <= '0;
            end
            if (bn_done) eng_busy <= 1'b0;
            if (pend_v && eng_free) begin
                bn_input <= pend;
                bn_start <= 1'b1;
                eng_busy <= 1'b1;
                pend_v   <= complete;
                if (complete) pend <= grp;
            end else if (complete && eng_free) begin
                bn_input <= grp;
                bn_start <= 1'b1;
                eng_busy <= 1'b1;
            end else if (complete) begin
                if (pend_v) begin
                    ovf <= 1'b1;
                end else begin
                    pend   <= grp;
                    pend_v <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - sequences weight load, ifmap streaming, ofmap writes and BN batching
module conv_seq_ctrl
    import conv_seq_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int TAPS     = 9,
    parameter int W_BASE   = W_BASE_DEF,
    parameter int BN_GROUP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          ifmap_len,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf,
    output logic                       rd_en,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic [31:0]                rd_data,
    output logic [TAPS*32-1:0]         weight,
    output logic [31:0]                conv_num,
    output logic                       conv_num_valid,
    input  logic                       conv_ready,
    input  logic [31:0]                dout,
    input  logic                       dout_valid,
    input  logic                       conv_done,
    output logic                       ofmap_we,
    output logic [ADDR_W-1:0]          ofmap_addr,
    output logic [31:0]                ofmap_wdata,
    output logic [BN_GROUP*LANE_W-1:0] bn_input,
    output logic                       bn_start,
    input  logic                       bn_done
);

    localparam int LW = $clog2(TAPS + 1);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [LW-1:0]     LONE  = LW'(1);
    localparam logic [LW-1:0]     LTAPS = LW'(TAPS);

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] xfer_cnt;
    logic [LW-1:0]     ld_cnt;
    logic              rd_pend;
    logic              cd_seen;
    logic              sk_v;
    logic [31:0]       sk_d;
    logic              accept;
    logic              xfer;
    logic              bn_idle;

    assign busy = (state != IDLE);

    always_comb begin
        nxt     = state;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        accept  = (state == IDLE) && start;
        xfer    = conv_num_valid && conv_ready;
        case (state)
            IDLE: if (start) nxt = LOAD_W;
            LOAD_W: begin
                rd_en   = ld_cnt < LTAPS;
                rd_addr = ADDR_W'(W_BASE) + ADDR_W'(ld_cnt);
                if (ld_cnt == LTAPS) nxt = (len_q == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                // never issue a read the skid could not absorb
                rd_en   = (rd_cnt < len_q) && conv_ready && !sk_v;
                rd_addr = rd_cnt;
                if (xfer && xfer_cnt == len_q - ONE) nxt = DRAIN;
            end
            DRAIN: begin
                if (cd_seen && bn_idle) begin
                    nxt  = IDLE;
                    done = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            len_q          <= '0;
            rd_cnt         <= '0;
            xfer_cnt       <= '0;
            ld_cnt         <= '0;
            rd_pend        <= 1'b0;
            cd_seen        <= 1'b0;
            sk_v           <= 1'b0;
            sk_d           <= '0;
            conv_num       <= '0;
            conv_num_valid <= 1'b0;
            weight         <= '0;
            ofmap_we       <= 1'b0;
            ofmap_addr     <= '0;
            ofmap_wdata    <= '0;
        end else begin
            state       <= nxt;
            rd_pend     <= rd_en && (state == STREAM);
            ofmap_we    <= dout_valid;
            ofmap_wdata <= dout;
            if (ofmap_we) ofmap_addr <= ofmap_addr + ONE;
            if (busy && conv_done) cd_seen <= 1'b1;
            if (state == LOAD_W) begin
                ld_cnt <= ld_cnt + LONE;
                if (ld_cnt != '0) weight[32*(int'(ld_cnt)-1) +: 32] <= rd_data;
            end
            if (state == STREAM && rd_en) rd_cnt <= rd_cnt + ONE;
            if (xfer) begin
                conv_num_valid <= 1'b0;
                xfer_cnt       <= xfer_cnt + ONE;
            end
            // skid word is older than any returning read, so it drains first
            if (sk_v && (xfer || !conv_num_valid)) begin
                conv_num       <= sk_d;
                conv_num_valid <= 1'b1;
                sk_v           <= 1'b0;
            end else if (rd_pend) begin
                if (xfer || !conv_num_valid) begin
                    conv_num       <= rd_data;
                    conv_num_valid <= 1'b1;
                end else begin
                    sk_d <= rd_data;
                    sk_v <= 1'b1;
                end
            end
            if (accept) begin
                len_q      <= ifmap_len;
                ld_cnt     <= '0;
                rd_cnt     <= '0;
                xfer_cnt   <= '0;
                cd_seen    <= 1'b0;
                ofmap_addr <= '0;
            end
        end
    end

    bn_packer #(
        .BN_GROUP(BN_GROUP)
    ) u_bn_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .lane_in   (dout[LANE_W-1:0]),
        .lane_valid(dout_valid),
        .flush     (conv_done),
        .bn_done   (bn_done),
        .bn_input  (bn_input),
        .bn_start  (bn_start),
        .ovf       (ovf),
        .idle      (bn_idle)
    );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - randomized self-checking bench for conv_seq_ctrl
`timescale 1ns/1ps
module tb_conv_seq_ctrl;

    localparam int ADDR_W = 13;
    localparam int TAPS   = 9;
    localparam int W_BASE = 4080;
    localparam int G      = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] ifmap_len;
    logic              busy, done, ovf;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic [TAPS*32-1:0] weight;
    logic [31:0]       conv_num;
    logic              conv_num_valid;
    logic              conv_ready;
    logic [31:0]       dout;
    logic              dout_valid;
    logic              conv_done;
    logic              ofmap_we;
    logic [ADDR_W-1:0] ofmap_addr;
    logic [31:0]       ofmap_wdata;
    logic [G*16-1:0]   bn_input;
    logic              bn_start;
    logic              bn_done;

    always #5 clk = ~clk;

    conv_seq_ctrl #(
        .ADDR_W(ADDR_W), .TAPS(TAPS), .W_BASE(W_BASE), .BN_GROUP(G)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ifmap_len(ifmap_len),
        .busy(busy), .done(done), .ovf(ovf),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .weight(weight),
        .conv_num(conv_num), .conv_num_valid(conv_num_valid), .conv_ready(conv_ready),
        .dout(dout), .dout_valid(dout_valid), .conv_done(conv_done),
        .ofmap_we(ofmap_we), .ofmap_addr(ofmap_addr), .ofmap_wdata(ofmap_wdata),
        .bn_input(bn_input), .bn_start(bn_start), .bn_done(bn_done)
    );

    // input SRAM: one-cycle read latency
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 32'h0;

    // BN engine: bn_done bn_lat cycles after bn_start, optionally withheld
    int bn_lat  = 2;
    bit bn_hold = 1'b0;
    int bn_cnt  = 0;
    always @(posedge clk) begin
        bn_done <= 1'b0;
        if (rst) bn_cnt <= 0;
        else if (bn_start) bn_cnt <= bn_lat - 1;
        else if (bn_cnt == 1) begin
            if (!bn_hold) begin
                bn_done <= 1'b1;
                bn_cnt  <= 0;
            end
        end else if (bn_cnt > 1) bn_cnt <= bn_cnt - 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] xq[$];
    logic [63:0] bq[$];
    logic [44:0] oq[$];
    int          bsq[$];
    int          bdq[$];
    logic [31:0] exp_x[$];
    logic [31:0] exp_d[$];
    logic [63:0] exp_b[$];
    int ifrd = 0, st_cyc = -1, ld_cyc = -1, hold_viol = 0;
    int done_cnt = 0, done_cyc = 0, cd_cyc = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (conv_num_valid && conv_ready) xq.push_back(conv_num);
            if (stall_prev && (!conv_num_valid || conv_num != stall_data)) hold_viol++;
            stall_prev = conv_num_valid && !conv_ready;
            stall_data = conv_num;
            if (bn_start) begin bq.push_back(bn_input); bsq.push_back(cyc); end
            if (bn_done) bdq.push_back(cyc);
            if (ofmap_we) oq.push_back({ofmap_addr, ofmap_wdata});
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (rd_en && rd_addr < W_BASE) begin ifrd++; if (st_cyc < 0) st_cyc = cyc; end
            if (rd_en && rd_addr == W_BASE && ld_cyc < 0) ld_cyc = cyc;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for 3 cycles mid-stream
    task automatic run_stream(input int len, input int mode);
        int n = 0;
        xq.delete(); bq.delete(); oq.delete(); bsq.delete(); bdq.delete();
        exp_x.delete(); exp_d.delete();
        ifrd = 0; st_cyc = -1; ld_cyc = -1; hold_viol = 0;
        for (int a = 0; a < len; a++) exp_x.push_back(mem[a]);
        ifmap_len = ADDR_W'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        while ((xq.size() < len || n < TAPS + 4) && n < 2000) begin
            if (mode == 1) conv_ready = ($urandom_range(3) != 0);
            else if (mode == 2) conv_ready = !(n >= TAPS + 4 && n <= TAPS + 6);
            else conv_ready = 1'b1;
            tick();
            n++;
        end
        conv_ready = 1'b1;
        check_val("stream_timeout", n < 2000, 1);
    endtask

    task automatic drive_results(input int n, input bit seq, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(2)) begin dout_valid = 1'b0; tick(); end
            dout       = seq ? 32'(i + 1) : $urandom;
            dout_valid = 1'b1;
            exp_d.push_back(dout);
            tick();
        end
        dout_valid = 1'b0;
    endtask

    task automatic end_job(input string tag);
        int d0 = done_cnt;
        int n  = 0;
        conv_done = 1'b1;
        cd_cyc    = cyc;
        tick();
        conv_done = 1'b0;
        while (done_cnt == d0 && n < 500) begin tick(); n++; end
        check_val({tag, "_done"}, done_cnt - d0, 1);
        check_val({tag, "_done_after_cd"}, done_cyc > cd_cyc, 1);
        tick(); tick();
        check_val({tag, "_busy_end"}, busy, 0);
    endtask

    // reference: ifmap order, one ofmap write per result, results chunked into zero-padded groups
    task automatic check_job(input string tag, input bit exp_ovf);
        int f0;
        logic [63:0] g = '0;
        exp_b.delete();
        for (int i = 0; i < exp_d.size(); i++) begin
            g[16*(i%G) +: 16] = exp_d[i][15:0];
            if (i % G == G - 1 || i == exp_d.size() - 1) begin exp_b.push_back(g); g = '0; end
        end
        check_val({tag, "_n_xfer"}, xq.size(), exp_x.size());
        f0 = n_fail;
        for (int i = 0; i < exp_x.size() && i < xq.size(); i++) begin
            check_val({tag, "_xfer"}, xq[i], exp_x[i]);
            if (n_fail != f0) break;
        end
        check_val({tag, "_n_ofmap"}, oq.size(), exp_d.size());
        f0 = n_fail;
        for (int i = 0; i < exp_d.size() && i < oq.size(); i++) begin
            check_val({tag, "_ofmap"}, oq[i], {ADDR_W'(i % (1 << ADDR_W)), exp_d[i]});
            if (n_fail != f0) break;
        end
        check_val({tag, "_n_bn"}, bq.size(), exp_b.size());
        f0 = n_fail;
        for (int i = 0; i < exp_b.size() && i < bq.size(); i++) begin
            check_val({tag, "_bn_group"}, bq[i], exp_b[i]);
            if (n_fail != f0) break;
        end
        check_val({tag, "_ovf"}, ovf, exp_ovf);
        check_val({tag, "_hold"}, hold_viol, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int d0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0; ifmap_len = '0; conv_ready = 1'b1;
        dout = '0; dout_valid = 1'b0; conv_done = 1'b0;
        repeat (3) tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ovf", ovf, 0);
        check_val("rst_rd_en", rd_en, 0);
        check_val("rst_cnv_valid", conv_num_valid, 0);
        check_val("rst_bn_start", bn_start, 0);
        check_val("rst_ofmap_we", ofmap_we, 0);
        check_val("rst_weight", weight[63:0], 0);
        rst = 1'b0;
        tick();

        // weight load and a 6-word stream with data equal to address
        for (int k = 0; k < TAPS; k++) mem[W_BASE + k] = 32'(k + 1);
        for (int a = 0; a < 6; a++) mem[a] = 32'(a);
        bn_lat = 2;
        run_stream(6, 0);
        for (int k = 0; k < TAPS; k++) check_val("weight_tap", weight[32*k +: 32], k + 1);
        check_val("load_to_stream", st_cyc - ld_cyc, TAPS + 1);
        drive_results(5, 0, 1);
        end_job("stream6");
        check_job("stream6", 0);

        // backpressure mid-stream
        for (int a = 0; a < 8; a++) mem[a] = $urandom;
        run_stream(8, 2);
        drive_results(3, 0, 0);
        end_job("bp8");
        check_job("bp8", 0);

        // two BN groups, second waits for bn_done
        bn_lat = 5;
        run_stream(1, 0);
        drive_results(8, 1, 0);
        end_job("bn8");
        check_job("bn8", 0);
        check_val("bn_latency", (bsq.size() > 0 && bdq.size() > 0) ? bdq[0] - bsq[0] : -1, 5);
        check_val("bn_pend_issue", (bsq.size() > 1 && bdq.size() > 0) ? bsq[1] - bdq[0] : -1, 1);

        // overrun with bn_done withheld
        bn_lat  = 2;
        bn_hold = 1'b1;
        run_stream(1, 0);
        drive_results(12, 1, 0);
        tick(); tick();
        check_val("ovr_ovf", ovf, 1);
        check_val("ovr_n_bn_held", bq.size(), 1);
        check_val("ovr_group0", bq.size() > 0 ? bq[0] : '0, pack4(1, 2, 3, 4));
        bn_hold = 1'b0;
        end_job("ovr");
        check_val("ovr_n_bn", bq.size(), 2);
        check_val("ovr_group1", bq.size() > 1 ? bq[1] : '0, pack4(5, 6, 7, 8));
        check_val("ovr_sticky", ovf, 1);

        // partial group flushed at conv_done; start clears ovf
        run_stream(1, 0);
        check_val("start_clr_ovf", ovf, 0);
        drive_results(6, 1, 0);
        end_job("partial");
        check_job("partial", 0);
        check_val("partial_group", bq.size() > 1 ? bq[1] : '0, pack4(5, 6, 0, 0));

        // empty ifmap
        run_stream(0, 0);
        check_val("len0_reads", ifrd, 0);
        end_job("len0");
        check_job("len0", 0);

        // randomized jobs
        for (int j = 0; j < 5; j++) begin
            len = $urandom_range(24, 1);
            for (int a = 0; a < len; a++) mem[a] = $urandom;
            bn_lat = $urandom_range(3, 2);
            run_stream(len, 1);
            drive_results($urandom_range(11, 1), 0, 1);
            end_job("rand");
            check_job("rand", 0);
        end

        // ofmap address wrap
        bn_lat = 2;
        run_stream(1, 0);
        drive_results((1 << ADDR_W) + 2, 0, 0);
        end_job("wrap");
        check_job("wrap", 0);

        // reset mid-stream aborts without done
        for (int a = 0; a < 20; a++) mem[a] = 32'(a);
        ifmap_len = ADDR_W'(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        check_val("pre_rst_busy", busy, 1);
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_valid", conv_num_valid, 0);
        check_val("abort_rd_en", rd_en, 0);
        repeat (10) tick();
        check_val("abort_no_done", done_cnt - d0, 0);
        check_val("abort_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter ADDR_W SHALL default to 13; it is the SRAM address width.
REQ-002 Parameter TAPS SHALL default to 9; it is the number of kernel weight words.
REQ-003 Parameter W_BASE SHALL default to 4080; it is the address of the first weight word.
REQ-004 Parameter BN_GROUP SHALL default to 4; it is the number of 16-bit results per BN batch.
REQ-005 clk  in  1  clock. The block SHALL use one clock; all logic is on the rising edge.
REQ-006 rst  in  1  reset. Reset SHALL be synchronous and active-high.
REQ-007 start  in  1  one-cycle job launch.
REQ-008 ifmap_len  in  ADDR_W  ifmap word count, sampled at start.
REQ-009 busy  out  1  job active. done  out  1  one-cycle end-of-job pulse. ovf  out  1  sticky BN overrun flag.
REQ-010 rd_en  out  1. rd_addr  out  ADDR_W. rd_data  in  32. This is the input SRAM port; read data arrives one cycle after rd_en.
REQ-011 weight  out  TAPS*32  packed weight words, tap 0 in the LSBs.
REQ-012 conv_num  out  32. conv_num_valid  out  1. conv_ready  in  1.
REQ-013 dout  in  32. dout_valid  in  1. conv_done  in  1. These come from the conv engine.
REQ-014 ofmap_we  out  1. ofmap_addr  out  ADDR_W. ofmap_wdata  out  32. This is the output SRAM write port.
REQ-015 bn_input  out  BN_GROUP*16. bn_start  out  1. bn_done  in  1. This is the BN engine handshake.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD_W, STREAM and DRAIN.
- IDLE->LOAD_W on start; start is ignored while busy=1.
- busy SHALL equal (state!=IDLE).
REQ-017 LOAD_W SHALL read W_BASE..W_BASE+TAPS-1 on consecutive cycles; returned word k is captured into tap k.
- LOAD_W->STREAM after the last tap is captured, i.e. TAPS+1 cycles in LOAD_W.
- weight SHALL hold stable until the next LOAD_W.
REQ-018 STREAM SHALL read addresses 0..ifmap_len-1 in order.
- Each returned word is presented on conv_num with conv_num_valid=1.
- A transfer occurs on conv_num_valid && conv_ready.
REQ-019 While conv_ready=0, conv_num and conv_num_valid SHALL hold.
- rd_en deasserts.
- A 1-entry skid register absorbs the in-flight word.
- No word is lost, duplicated or reordered.
REQ-020 If ifmap_len=0, LOAD_W SHALL go directly to DRAIN with no ifmap reads.
REQ-021 STREAM->DRAIN on transfer of the last word.
REQ-022 DRAIN->IDLE when conv_done has been seen in this job, no BN group is pending and the BN engine is idle.
- done pulses in the exit cycle.
REQ-023 Ofmap writes SHALL follow each dout_valid by one cycle: ofmap_we=1, ofmap_wdata=dout.
- ofmap_addr starts at 0 per job and increments after each write.
- ofmap_addr wraps from 2^ADDR_W-1 to 0.
REQ-024 BN packing: dout[15:0] of the k-th result in a group SHALL occupy lane k, bits [16k+15:16k].
REQ-025 On group completion with the BN engine idle, bn_input SHALL load and bn_start pulses the next cycle.
- The BN engine is busy from bn_start until bn_done.
REQ-026 A group completing while the BN engine is busy SHALL be held pending and issued the cycle after bn_done.
- A further completion while a group is pending is dropped and sets ovf.
REQ-027 If bn_done and group completion occur in the same cycle, the group SHALL issue the next cycle without a pending stall.
REQ-028 A partial group at conv_done SHALL issue with its unused lanes zero.

Reset
REQ-029 While rst=1, all outputs, counters and registers SHALL clear and the state SHALL go to IDLE.
- rst mid-job aborts the job with no done pulse.
REQ-030 ovf SHALL clear on rst and on an accepted start.

Structure
REQ-031 Package conv_seq_pkg SHALL hold the state enum, the W_BASE default and the LANE_W=16 constant.
REQ-032 Sub-module bn_packer SHALL implement lane packing, the pending slot, ovf and the BN handshake.

Verification
REQ-033 Weight load: SRAM[4080+k]=k+1, start -> weight tap k = k+1; STREAM entered 10 cycles after LOAD_W entry.
REQ-034 Stream: ifmap_len=6, conv_ready=1 -> conv_num sequence 0..5 (data=addr), done after conv_done.
REQ-035 Backpressure: ifmap_len=8, conv_ready low 3 cycles mid-stream -> exactly 8 in-order transfers, no duplicates.
REQ-036 BN: 8 dout_valid with dout=1..8, bn_done 5 cycles after bn_start -> groups {1,2,3,4} and {5,6,7,8}, second issued after bn_done, ovf=0.
REQ-037 Overrun and partial: 12 results while bn_done withheld -> ovf=1; 6 results then conv_done -> second group {5,6,0,0}.
REQ-038 ifmap_len=0 -> no ifmap reads, done after conv_done; rst mid-STREAM -> IDLE, busy=0, no done.
